gru_state_collector: RTL

- Downstream of the GRU cell. Captures each quantized hidden-state word (EP elements) when the cell asserts its hidden-state write strobe.
- Tags each word with its word index and time step, and buffers it in a first-word-fall-through FIFO.
- Streams the words to the next consumer (dense layer or host DMA) over a valid/ready handshake, flagging the end of each step and of the whole sequence.

---
 rtl/gru_state_collector.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/gru_state_collector.sv
// ---------------------------------------------------------------------------
// gru_state_collector
//
// Purpose:
//   Sits downstream of the GRU cell.  Every time the cell strobes a quantized
//   hidden-state word, the word is tagged with its word index inside the
//   current time step and with the time-step index.  The tagged entry is
//   buffered in a first-word-fall-through FIFO.  The FIFO head is streamed to
//   the next consumer (dense layer or host DMA) over a valid/ready handshake.
//   The end of each step and the end of the whole sequence are flagged
//   alongside the data.  Data words pass through bit-exact.
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high; clears everything incl. overflow
//   flush         synchronous clear of FIFO and tag counters; overflow kept
//   in_valid      hidden-state write strobe from the GRU cell (we_h)
//   in_data       quantized hidden-state word, DW bits
//   out_valid     FIFO head valid
//   out_ready     consumer accepts the head
//   out_data      head word
//   out_word      word index of the head within its step, 0..WPS-1
//   out_step      time-step index of the head, 0..time_steps-1
//   out_last      head is the last word of its step
//   out_seq_last  head is the last word of the last step
//   fill          FIFO occupancy, 0..DEPTH
//   overflow      sticky flag: a word arrived while the FIFO was full
//   seq_done      one-cycle pulse after the final word of a sequence is
//                 written into the FIFO
// ---------------------------------------------------------------------------
module gru_state_collector #(
   parameter  int EP         = 48,
   parameter  int WI_vec     = 4,
   parameter  int WF_vec     = 12,
   parameter  int gru_size   = 624,
   parameter  int time_steps = 2,
   parameter  int DEPTH      = 16,
   localparam int DW         = EP * (WI_vec + WF_vec),
   localparam int FW         = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [7:0]    out_word,
   output logic [7:0]    out_step,
   output logic          out_last,
   output logic          out_seq_last,
   output logic [FW-1:0] fill,
   output logic          overflow,
   output logic          seq_done
);

   // Words per time step and FIFO geometry.
   localparam int WPS = gru_size / EP;
   localparam int AW  = $clog2(DEPTH);

   // A stored entry is {data, word index, step index, last, seq_last}.
   localparam int EW  = DW + 8 + 8 + 1 + 1;

   localparam logic [7:0]    LAST_WORD = 8'(WPS - 1);
   localparam logic [7:0]    LAST_STEP = 8'(time_steps - 1);
   localparam logic [FW-1:0] FULL      = FW'(DEPTH);

   // Entry storage.  Deliberately not reset: the head is masked by
   // head_blank until something has actually been written after a
   // reset or flush, so stale contents never reach the outputs then.
   logic [EW-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    word_ctr;
   logic [7:0]    step_ctr;
   logic          head_blank;

   logic          pop;
   logic          push;
   logic          drop;
   logic          has_room;
   logic          word_last;
   logic          entry_seq_last;
   logic [EW-1:0] wr_entry;
   logic [EW-1:0] head;

   // The head is valid whenever anything is stored.
   assign out_valid = (fill != '0);

   // Handshake decode.  A full FIFO still accepts a word in the same cycle
   // that the consumer pops, because the pop frees the slot on the same edge.
   // A flush discards the incoming word outright, and that is not counted as
   // a drop.
   always_comb begin
      has_room       = (fill < FULL);
      pop            = out_valid && out_ready;
      push           = in_valid && !flush && (has_room || pop);
      drop           = in_valid && !flush && !has_room && !pop;
      word_last      = (word_ctr == LAST_WORD);
      entry_seq_last = word_last && (step_ctr == LAST_STEP);
      wr_entry       = {in_data, word_ctr, step_ctr, word_last, entry_seq_last};
   end

   // Write the tagged entry into the slot the write pointer names.
   // Reset takes priority over any strobe arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Pointer and occupancy bookkeeping.  The pointers wrap naturally at
   // DEPTH; fill carries one extra bit so that full and empty stay distinct.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fill <= fill + FW'(1);
            2'b01:   fill <= fill - FW'(1);
            default: fill <= fill;
         endcase
      end
   end

   // Tag counters move only on an accepted push.  A dropped word leaves them
   // untouched, so the tags of the words that were accepted stay contiguous.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         word_ctr <= '0;
         step_ctr <= '0;
      end else if (push) begin
         if (word_last) begin
            word_ctr <= '0;
            if (step_ctr == LAST_STEP) begin
               step_ctr <= '0;
            end else begin
               step_ctr <= step_ctr + 8'd1;
            end
         end else begin
            word_ctr <= word_ctr + 8'd1;
         end
      end
   end

   // seq_done pulses for the one cycle after the final word of a sequence
   // has been written.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         seq_done <= 1'b0;
      end else begin
         seq_done <= push && entry_seq_last;
      end
   end

   // overflow is sticky until reset; flush deliberately leaves it alone so
   // the host can still see that data was lost before the flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end
   end

   // head_blank forces the presented head to zero after reset or flush
   // until the next accepted push.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_blank <= 1'b1;
      end else if (push) begin
         head_blank <= 1'b0;
      end
   end

   // Fall-through head: read straight from registered storage at the read
   // pointer, so it stays stable while the consumer stalls.
   always_comb begin
      head = mem[rd_ptr];
      if (head_blank) begin
         head = '0;
      end
   end

   assign out_data     = head[EW-1 -: DW];
   assign out_word     = head[17:10];
   assign out_step     = head[9:2];
   assign out_last     = head[1];
   assign out_seq_last = head[0];

endmodule
